// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot timer: counts cycles within a slot (blank + drive) and flags phase ends.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = 25000,
  parameter int BLANK_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_run,
  output logic                       o_blank_done,
  output logic                       o_slot_done,
  output logic [$clog2(CLK_DIV)-1:0] o_dcnt
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;

  assign o_slot_done  = i_run && (r_cnt == CW'(CLK_DIV - 1));
  // With no blank phase there is no blank end to report.
  assign o_blank_done = i_run && (BLANK_CYC != 0) && (r_cnt == CW'(BLANK_CYC - 1));
  assign o_dcnt       = r_cnt - CW'(BLANK_CYC);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= o_slot_done ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with per-frame input snapshot.
// Optional brightness control is enabled by defining SEG_DIM_EN.
//
// state | meaning
// IDLE  | display dark, waiting for enable
// BLANK | anti-ghosting gap at the start of a slot, all anodes off
// DRIVE | current digit driven (subject to dimming window)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 25000,
  parameter int BLANK_CYC  = 64,
  parameter int AN_ACT_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
`ifdef SEG_DIM_EN
  input  logic [2:0] dim_level,
`endif
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [7:0] seg_in_4,
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  localparam int         CW     = $clog2(CLK_DIV);
  localparam logic [3:0] AN_OFF = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;

  state_t        r_state;
  digit_idx_t    r_idx;
  logic [7:0]    r_snap [4];
  logic [7:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_tick;

  logic          w_blank_done;
  logic          w_slot_done;
  logic [CW-1:0] w_dcnt;
  logic          w_frame_start;
  logic          w_to_drive;
  digit_idx_t    w_nxt_idx;
  logic [CW-1:0] w_nxt_dcnt;
  logic [7:0]    w_nxt_byte;
  logic [3:0]    w_onehot;
  logic [3:0]    w_an_on;
  logic          w_lit;

  seg_slot_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (!enable),
    .i_run        (enable && (r_state != IDLE)),
    .o_blank_done (w_blank_done),
    .o_slot_done  (w_slot_done),
    .o_dcnt       (w_dcnt)
  );

  always_comb begin
    w_frame_start = 1'b0;
    w_to_drive    = 1'b0;
    w_nxt_idx     = r_idx;
    w_nxt_dcnt    = '0;
    case (r_state)
      IDLE: begin
        w_frame_start = 1'b1;
        w_nxt_idx     = '0;
        w_to_drive    = (BLANK_CYC == 0);
      end
      BLANK: begin
        w_to_drive = w_blank_done;
      end
      DRIVE: begin
        if (w_slot_done) begin
          w_nxt_idx     = r_idx + 1'b1;
          w_frame_start = (r_idx == 2'd3);
          w_to_drive    = (BLANK_CYC == 0);
        end else begin
          w_to_drive = 1'b1;
          w_nxt_dcnt = w_dcnt + 1'b1;
        end
      end
      default: ;
    endcase
    // A frame start drives digit 0 straight from the input being captured this edge.
    w_nxt_byte = w_frame_start ? seg_in_1 : r_snap[w_nxt_idx];
    w_onehot   = 4'b0001 << w_nxt_idx;
    w_an_on    = (AN_ACT_LOW != 0) ? ~w_onehot : w_onehot;
  end

`ifdef SEG_DIM_EN
  localparam int PW = CW + 4;

  logic [2:0]    r_dim_q;
  logic [2:0]    w_nxt_dim;
  logic [PW-1:0] w_prod;

  assign w_nxt_dim = w_frame_start ? dim_level : r_dim_q;
  assign w_prod    = PW'(CLK_DIV - BLANK_CYC) * (PW'(w_nxt_dim) + 1'b1);
  assign w_lit     = PW'(w_nxt_dcnt) < (w_prod >> 3);
`else
  assign w_lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_seg     <= SEG_BLANK;
      r_an      <= AN_OFF;
      r_tick    <= 1'b0;
      r_snap[0] <= SEG_BLANK;
      r_snap[1] <= SEG_BLANK;
      r_snap[2] <= SEG_BLANK;
      r_snap[3] <= SEG_BLANK;
`ifdef SEG_DIM_EN
      r_dim_q   <= 3'd7;
`endif
    end else if (!enable) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_seg   <= SEG_BLANK;
      r_an    <= AN_OFF;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_frame_start;
      r_idx   <= w_nxt_idx;
      r_state <= w_to_drive ? DRIVE : BLANK;
      if (w_frame_start) begin
        r_snap[0] <= seg_in_1;
        r_snap[1] <= seg_in_2;
        r_snap[2] <= seg_in_3;
        r_snap[3] <= seg_in_4;
`ifdef SEG_DIM_EN
        r_dim_q   <= dim_level;
`endif
      end
      if (w_to_drive && w_lit) begin
        r_seg <= w_nxt_byte;
        r_an  <= w_an_on;
      end else begin
        r_seg <= SEG_BLANK;
        r_an  <= AN_OFF;
      end
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (CLK_DIV=16, BLANK_CYC=4, active-low anodes).
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] seg_in_1, seg_in_2, seg_in_3, seg_in_4;
  logic [2:0] dim_level = 3'd7;
  logic [7:0] seg_out;
  logic [3:0] an_out;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] f_a [4];
  logic [7:0] f_b [4];

  seg_scan_ctrl #(
    .CLK_DIV    (16),
    .BLANK_CYC  (4),
    .AN_ACT_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef SEG_DIM_EN
    .dim_level  (dim_level),
`endif
    .seg_in_1   (seg_in_1),
    .seg_in_2   (seg_in_2),
    .seg_in_3   (seg_in_3),
    .seg_in_4   (seg_in_4),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Observed/expected are packed as {an_out, seg_out, frame_tick}.
  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got an=%b seg=%h tick=%b, expected an=%b seg=%h tick=%b",
               tag, got[12:9], got[8:1], got[0], exp[12:9], exp[8:1], exp[0]);
    end
  endtask

  // Frame cycle c: slot c/16, first 4 cycles blank, then `lit` cycles of the digit.
  task automatic run_cycles(input string tag, input logic [7:0] b [4], input int lit,
                            input int c_from, input int c_to);
    for (int c = c_from; c <= c_to; c++) begin
      int         slot;
      int         ph;
      logic [3:0] ea;
      logic [7:0] es;
      slot = c / 16;
      ph   = c % 16;
      ea   = 4'hF;
      es   = 8'hFF;
      if (ph >= 4 && (ph - 4) < lit) begin
        ea = 4'hF ^ (4'b0001 << slot);
        es = b[slot];
      end
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, c), {an_out, seg_out, frame_tick}, {ea, es, (c == 0)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    f_a = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    f_b = '{8'hC0, 8'hF9, 8'h92, 8'hB0};
    seg_in_1 = 8'hC0;
    seg_in_2 = 8'hF9;
    seg_in_3 = 8'hA4;
    seg_in_4 = 8'hB0;

    // reset held with enable high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d", i), {an_out, seg_out, frame_tick}, {4'hF, 8'hFF, 1'b0});
    end
    rst = 1'b0;

    run_cycles("frame1", f_a, 12, 0, 63);

    // mid-frame input change is held off until the next frame
    run_cycles("tear", f_a, 12, 0, 20);
    seg_in_3 = 8'h92;
    run_cycles("tear", f_a, 12, 21, 63);
    run_cycles("frame3", f_b, 12, 0, 63);

    // disable during digit 2 drive, then re-enable
    run_cycles("pre_dis", f_b, 12, 0, 40);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("disabled%0d", i), {an_out, seg_out, frame_tick}, {4'hF, 8'hFF, 1'b0});
    end
    enable = 1'b1;
    run_cycles("reen", f_b, 12, 0, 63);

    // one-cycle reset mid-frame
    run_cycles("pre_rst", f_b, 12, 0, 25);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset", {an_out, seg_out, frame_tick}, {4'hF, 8'hFF, 1'b0});
    rst = 1'b0;
    run_cycles("post_rst", f_b, 12, 0, 63);

`ifdef SEG_DIM_EN
    // dim_level=3 -> 6 lit cycles; change mid-frame takes effect next frame
    dim_level = 3'd3;
    run_cycles("dim3", f_b, 6, 0, 20);
    dim_level = 3'd0;
    run_cycles("dim3", f_b, 6, 21, 63);
    run_cycles("dim0", f_b, 1, 0, 63);
    dim_level = 3'd7;
    run_cycles("dim7", f_b, 12, 0, 63);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
